// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 pipeline definitions. It holds the stat codes, the
// icodes, the register IDs and the bubble (NOP) control bundle. All pipeline
// stage registers and the hazard unit use this package.
package y86_pkg;

  // Status codes carried with every instruction
  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] RNONE = 4'hF;

  // Control part of a stage bundle. The value words travel beside it.
  typedef struct packed {
    logic [2:0] stat;
    logic [3:0] icode;
    logic [3:0] rA;
    logic [3:0] rB;
    logic       cnd;
  } ctl_t;

  localparam ctl_t BUB_CTL = '{stat: SBUB, icode: INOP, rA: RNONE, rB: RNONE, cnd: 1'b0};

  function automatic logic is_exc(input logic [2:0] s);
    return (s == SHLT) || (s == SADR) || (s == SINS);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that saturates at all-ones instead of wrapping.
//   clk, rst (async, active-high) ; inc : count this edge ; count : value
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      count <= '0;
    else if (inc && count != MAX) count <= count + ONE;
  end

endmodule

// File: rtl/y86_pipe_reg.sv
// y86_pipe_reg: Y86-64 pipeline stage register (F/D, D/E, E/M, M/W).
// It carries stat/icode/rA/rB/cnd plus NUM_VAL words of DATA_W bits.
//   clk, rst          : clock, async active-high reset (loads bubble bundle)
//   stall / bubble    : hold contents / load NOP bubble (bubble wins)
//   in_*  / out_*     : incoming / registered bundle, word k at [k*DATA_W +: DATA_W]
//   out_valid         : out_stat != SBUB
//   frozen            : an exception was latched; the register holds until reset
//   ctl_err           : sticky; stall and bubble were seen together
//   stall_cnt/bubble_cnt : saturating event counters
module y86_pipe_reg
  import y86_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int NUM_VAL     = 6,
  parameter bit HALT_ON_EXC = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      bubble,
  input  logic [2:0]                in_stat,
  input  logic [3:0]                in_icode,
  input  logic [3:0]                in_rA,
  input  logic [3:0]                in_rB,
  input  logic                      in_cnd,
  input  logic [NUM_VAL*DATA_W-1:0] in_val,
  output logic [2:0]                out_stat,
  output logic [3:0]                out_icode,
  output logic [3:0]                out_rA,
  output logic [3:0]                out_rB,
  output logic                      out_cnd,
  output logic [NUM_VAL*DATA_W-1:0] out_val,
  output logic                      out_valid,
  output logic                      frozen,
  output logic                      ctl_err,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          bubble_cnt
);

  localparam int VW = NUM_VAL * DATA_W;

  ctl_t          ctl_q;
  logic [VW-1:0] val_q;
  logic          frz_q, err_q;
  logic          bub_en, stl_en, load_en;

  // A freeze masks everything, and bubble has priority over stall.
  always_comb begin
    bub_en  = !frz_q && bubble;
    stl_en  = !frz_q && stall && !bubble;
    load_en = !frz_q && !stall && !bubble;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q <= BUB_CTL;
      val_q <= '0;
    end else if (bub_en) begin
      ctl_q <= BUB_CTL;
      val_q <= '0;
    end else if (load_en) begin
      ctl_q <= '{stat: in_stat, icode: in_icode, rA: in_rA, rB: in_rB, cnd: in_cnd};
      val_q <= in_val;
    end
  end

  // The freeze is set on the same edge that captures the exception, so the
  // faulting instruction stays visible at the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frz_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (HALT_ON_EXC && load_en && is_exc(in_stat)) frz_q <= 1'b1;
      if (bub_en && stall)                           err_q <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(stl_en), .count(stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .inc(bub_en), .count(bubble_cnt)
  );

  assign out_stat  = ctl_q.stat;
  assign out_icode = ctl_q.icode;
  assign out_rA    = ctl_q.rA;
  assign out_rB    = ctl_q.rB;
  assign out_cnd   = ctl_q.cnd;
  assign out_val   = val_q;
  assign out_valid = (ctl_q.stat != SBUB);
  assign frozen    = frz_q;
  assign ctl_err   = err_q;

endmodule

// File: tb/tb_y86_pipe_reg.sv
// Scoreboard bench for y86_pipe_reg. Instance 0 uses the defaults
// (HALT_ON_EXC=1, CNT_W=32). Instance 1 uses HALT_ON_EXC=0 and CNT_W=4.
// Both instances receive the same stimulus.
module tb_y86_pipe_reg;
  localparam int DW = 64;
  localparam int NV = 6;
  localparam int VW = DW * NV;

  logic          clk = 1'b0, rst = 1'b0, stall = 1'b0, bubble = 1'b0, in_cnd = 1'b0;
  logic [2:0]    in_stat = '0;
  logic [3:0]    in_icode = '0, in_rA = '0, in_rB = '0;
  logic [VW-1:0] in_val = '0;

  logic [2:0]    o0_stat, o1_stat;
  logic [3:0]    o0_icode, o0_rA, o0_rB, o1_icode, o1_rA, o1_rB;
  logic          o0_cnd, o1_cnd, o0_valid, o1_valid, o0_frozen, o1_frozen, o0_err, o1_err;
  logic [VW-1:0] o0_val, o1_val;
  logic [31:0]   o0_sc, o0_bc;
  logic [3:0]    o1_sc, o1_bc;

  always #5 clk = ~clk;

  y86_pipe_reg #(.DATA_W(DW), .NUM_VAL(NV), .HALT_ON_EXC(1'b1), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_rA(in_rA), .in_rB(in_rB),
    .in_cnd(in_cnd), .in_val(in_val),
    .out_stat(o0_stat), .out_icode(o0_icode), .out_rA(o0_rA), .out_rB(o0_rB),
    .out_cnd(o0_cnd), .out_val(o0_val), .out_valid(o0_valid), .frozen(o0_frozen),
    .ctl_err(o0_err), .stall_cnt(o0_sc), .bubble_cnt(o0_bc));

  y86_pipe_reg #(.DATA_W(DW), .NUM_VAL(NV), .HALT_ON_EXC(1'b0), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_rA(in_rA), .in_rB(in_rB),
    .in_cnd(in_cnd), .in_val(in_val),
    .out_stat(o1_stat), .out_icode(o1_icode), .out_rA(o1_rA), .out_rB(o1_rB),
    .out_cnd(o1_cnd), .out_val(o1_val), .out_valid(o1_valid), .frozen(o1_frozen),
    .ctl_err(o1_err), .stall_cnt(o1_sc), .bubble_cnt(o1_bc));

  typedef struct {
    logic [2:0]    stat;
    logic [3:0]    icode, ra, rb;
    logic          cnd;
    logic [VW-1:0] val;
    logic          vld, frz, err;
    longint        sc, bc;
  } st_t;

  st_t    m [2];
  longint cmax [2] = '{64'd4294967295, 64'd15};
  bit     halt [2] = '{1'b1, 1'b0};
  st_t    q0 [$];
  st_t    q1 [$];
  int     checks = 0, failures = 0;
  bit     mon_en = 1'b0;

  function automatic st_t reset_state();
    st_t s;
    s.stat = 3'd0; s.icode = 4'h1; s.ra = 4'hF; s.rb = 4'hF; s.cnd = 1'b0;
    s.val = '0; s.vld = 1'b0; s.frz = 1'b0; s.err = 1'b0; s.sc = 0; s.bc = 0;
    return s;
  endfunction

  function automatic st_t act(input int k);
    st_t a;
    if (k == 0) begin
      a.stat = o0_stat; a.icode = o0_icode; a.ra = o0_rA; a.rb = o0_rB; a.cnd = o0_cnd;
      a.val = o0_val; a.vld = o0_valid; a.frz = o0_frozen; a.err = o0_err;
      a.sc = longint'(o0_sc); a.bc = longint'(o0_bc);
    end else begin
      a.stat = o1_stat; a.icode = o1_icode; a.ra = o1_rA; a.rb = o1_rB; a.cnd = o1_cnd;
      a.val = o1_val; a.vld = o1_valid; a.frz = o1_frozen; a.err = o1_err;
      a.sc = longint'(o1_sc); a.bc = longint'(o1_bc);
    end
    return a;
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] a, input logic [VW-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic cmp(input string tg, input int k, input st_t e);
    st_t a;
    a = act(k);
    chk($sformatf("%s%0d_stat", tg, k),  VW'(a.stat),  VW'(e.stat));
    chk($sformatf("%s%0d_icode", tg, k), VW'(a.icode), VW'(e.icode));
    chk($sformatf("%s%0d_rA", tg, k),    VW'(a.ra),    VW'(e.ra));
    chk($sformatf("%s%0d_rB", tg, k),    VW'(a.rb),    VW'(e.rb));
    chk($sformatf("%s%0d_cnd", tg, k),   VW'(a.cnd),   VW'(e.cnd));
    chk($sformatf("%s%0d_val", tg, k),   a.val,        e.val);
    chk($sformatf("%s%0d_valid", tg, k), VW'(a.vld),   VW'(e.stat != 3'd0));
    chk($sformatf("%s%0d_frozen", tg, k), VW'(a.frz),  VW'(e.frz));
    chk($sformatf("%s%0d_ctl_err", tg, k), VW'(a.err), VW'(e.err));
    chk($sformatf("%s%0d_stall_cnt", tg, k), VW'(a.sc), VW'(e.sc));
    chk($sformatf("%s%0d_bubble_cnt", tg, k), VW'(a.bc), VW'(e.bc));
  endtask

  // Reference model: one clock edge, following the documented priority rules.
  task automatic step(input logic s, input logic b, input logic [2:0] st, input logic [3:0] ic,
                      input logic [3:0] ra, input logic [3:0] rb, input logic c,
                      input logic [VW-1:0] v);
    for (int k = 0; k < 2; k++) begin
      if (m[k].frz) continue;
      if (b) begin
        m[k].stat = 3'd0; m[k].icode = 4'h1; m[k].ra = 4'hF; m[k].rb = 4'hF;
        m[k].cnd = 1'b0; m[k].val = '0;
        if (m[k].bc < cmax[k]) m[k].bc = m[k].bc + 1;
        if (s) m[k].err = 1'b1;
      end else if (s) begin
        if (m[k].sc < cmax[k]) m[k].sc = m[k].sc + 1;
      end else begin
        m[k].stat = st; m[k].icode = ic; m[k].ra = ra; m[k].rb = rb; m[k].cnd = c; m[k].val = v;
        if (halt[k] && st >= 3'd2 && st <= 3'd4) m[k].frz = 1'b1;
      end
    end
  endtask

  // Drive at the current negedge, push the expected outcome of the next edge,
  // and return at the following negedge.
  task automatic cyc(input logic s, input logic b, input logic [2:0] st, input logic [3:0] ic,
                     input logic [3:0] ra, input logic [3:0] rb, input logic c,
                     input logic [VW-1:0] v);
    stall = s; bubble = b; in_stat = st; in_icode = ic; in_rA = ra; in_rB = rb;
    in_cnd = c; in_val = v;
    step(s, b, st, ic, ra, rb, c, v);
    q0.push_back(m[0]);
    q1.push_back(m[1]);
    @(negedge clk);
  endtask

  // Reset is asserted partway through the high phase. The outputs must react
  // before any further clock edge.
  task automatic do_reset();
    mon_en = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    cmp("rst", 0, reset_state());
    cmp("rst", 1, reset_state());
    m[0] = reset_state();
    m[1] = reset_state();
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  function automatic logic [VW-1:0] rand_val();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Monitor: compare both instances shortly after every active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (q0.size() == 0 || q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL scoreboard_empty actual=%0d required=1", q0.size());
        end else begin
          cmp("mon", 0, q0.pop_front());
          cmp("mon", 1, q1.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] v, va, vb;
    logic s, b;
    logic [2:0] st;
    m[0] = reset_state();
    m[1] = reset_state();
    do_reset();

    // basic load
    v = '0;
    v[4*DW +: DW] = 64'hDEAD_BEEF;
    cyc(0, 0, 3'd1, 4'h6, 4'h2, 4'h3, 1'b0, v);

    // load A, stall 3 edges with B presented, then B loads
    va = rand_val();
    vb = rand_val();
    cyc(0, 0, 3'd1, 4'h3, 4'h1, 4'h5, 1'b1, va);
    repeat (3) cyc(1, 0, 3'd1, 4'h7, 4'h8, 4'h9, 1'b0, vb);
    cyc(0, 0, 3'd1, 4'h7, 4'h8, 4'h9, 1'b0, vb);

    // single bubble, then stall+bubble together
    cyc(0, 1, 3'd1, 4'h2, 4'h4, 4'h6, 1'b1, rand_val());
    cyc(1, 1, 3'd1, 4'h2, 4'h4, 4'h6, 1'b1, rand_val());
    cyc(0, 0, 3'd1, 4'h5, 4'h0, 4'h1, 1'b0, rand_val());
    do_reset();

    // exception freezes instance 0 only
    cyc(0, 0, 3'd3, 4'h5, 4'h3, 4'h4, 1'b0, rand_val());
    cyc(0, 0, 3'd1, 4'h6, 4'h1, 4'h2, 1'b1, rand_val());
    cyc(0, 1, 3'd1, 4'h6, 4'h1, 4'h2, 1'b1, rand_val());
    cyc(1, 0, 3'd1, 4'hA, 4'h1, 4'h2, 1'b0, rand_val());
    do_reset();

    // saturation of the 4-bit counter, then async reset mid-stall
    repeat (20) cyc(1, 0, 3'd1, 4'h6, 4'h1, 4'h2, 1'b0, rand_val());
    do_reset();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 60 == 59) do_reset();
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 5) == 0);
      if (s && b && m[0].frz) s = 1'b0;
      st = ($urandom_range(0, 19) != 0) ? 3'd1 : 3'($urandom_range(0, 4));
      cyc(s, b, st, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), rand_val());
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
